// File: rtl/noc_pkg.sv
// noc_pkg: shared flit width, address field bounds and flit/source types for the merge network
package noc_pkg;
    localparam int FLIT_W  = 9;
    localparam int ADDR_HI = 8;
    localparam int ADDR_LO = 5;
    typedef logic [FLIT_W-1:0] flit_t;
    typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_t;
endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: DEPTH-entry flit FIFO; pointers carry one extra wrap bit so full and empty differ
module noc_fifo
    import noc_pkg::*;
#(
    parameter int W     = FLIT_W,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] push_data,
    input  logic         push_valid,
    output logic         push_ready,
    output logic [W-1:0] pop_data,
    output logic         pop_valid,
    input  logic         pop
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         alive;
    logic         full;
    always_comb begin
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        push_ready = alive && !full;
        pop_valid  = wr_ptr != rd_ptr;
        pop_data   = mem[rd_ptr[AW-1:0]];
    end
    // alive keeps ready low until the first edge after reset release
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            alive  <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (push_valid && push_ready) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && pop_valid) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge CLK) begin
        if (push_valid && push_ready) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/arb2_merge.sv
// arb2_merge: two buffered inputs merged round-robin into one registered output stream.
// Define ARB2_MERGE_STATS_EN to add saturating per-input grant counters.
module arb2_merge
    import noc_pkg::*;
#(
    parameter int W     = FLIT_W,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef ARB2_MERGE_STATS_EN
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1,
`endif
    output logic         out_src
);
    logic [W-1:0] d0, d1;
    logic         v0, v1, pop0, pop1, load;
    src_t         grant, last;
    noc_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
        .CLK(CLK), ._RESET(_RESET),
        .push_data(in0_data), .push_valid(in0_valid), .push_ready(in0_ready),
        .pop_data(d0), .pop_valid(v0), .pop(pop0)
    );
    noc_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
        .CLK(CLK), ._RESET(_RESET),
        .push_data(in1_data), .push_valid(in1_valid), .push_ready(in1_ready),
        .pop_data(d1), .pop_valid(v1), .pop(pop1)
    );
    always_comb begin
        grant = (v0 && v1) ? src_t'(~last) : src_t'(v1);
        load  = (!out_valid || out_ready) && (v0 || v1);
        pop0  = load && grant == SRC0;
        pop1  = load && grant == SRC1;
    end
    // last starts at SRC1 so input 0 wins the first tie
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            last      <= SRC1;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= grant == SRC1 ? d1 : d0;
            out_src   <= grant;
            last      <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`ifdef ARB2_MERGE_STATS_EN
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (pop0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (pop1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: doc/arb2_merge.md
ARB2_MERGE -- requirements
Module: arb2_merge

Interface
REQ-001 SHALL have parameter W, default 9, meaning flit width (bits [8:5] address, [4:0] payload).
REQ-002 SHALL have parameter DEPTH, default 2, meaning entries per input FIFO (power of two, >=2).
REQ-003 SHALL have port CLK  input  1  clock, rising-edge.
REQ-004 SHALL have port _RESET  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in0_data/in1_data  input  W  flits from the two upstream decoder outputs (Out0/Out1 of neighbouring decoders).
REQ-006 SHALL have ports in0_valid/in1_valid  input  1, and in0_ready/in1_ready  output  1  per-input handshake.
REQ-007 SHALL have ports out_data  output  W, out_valid  output  1, out_ready  input  1  merged flit stream.
REQ-008 SHALL have port out_src  output  1  index of input that supplied out_data; valid when out_valid=1.

Function
REQ-009 SHALL transfer a flit on any port only in a cycle where valid=1 and ready=1 at the rising CLK edge.
REQ-010 SHALL buffer each input in its own DEPTH-entry FIFO; inN_ready = FIFO not full, independent of out_ready.
REQ-011 SHALL hold out_data/out_src/out_valid stable while out_valid=1 and out_ready=0.
REQ-012 SHALL load the output register when it is empty or draining in the same cycle, from a non-empty FIFO chosen by arbitration.
REQ-013 SHALL arbitrate round-robin: if both FIFOs non-empty, grant the input not granted last; if one non-empty, grant it; last-grant pointer updates only on a grant.
REQ-014 SHALL have latency 1 cycle: flit accepted at edge N into empty FIFO with empty output register appears with out_valid=1 after edge N+1... i.e. visible in cycle N+1.
REQ-015 SHALL sustain one flit per cycle out when out_ready=1 continuously and any FIFO non-empty.
REQ-016 SHALL preserve per-input order; no flit duplicated or dropped.
REQ-017 SHALL, for FIFO full with simultaneous pop, still drive inN_ready=0 that cycle (no push-through).
REQ-018 SHALL wrap FIFO read/write pointers modulo DEPTH using an extra bit for full/empty disambiguation.

Reset
REQ-019 SHALL, on _RESET=0, asynchronously clear both FIFOs, out_valid=0, out_data=0, out_src=0, last-grant=1 (input 0 wins first tie).
REQ-020 SHALL drive in0_ready=in1_ready=0 during reset and 1 from the first edge after release.
REQ-021 SHALL discard all buffered and in-flight flits on reset mid-operation.

Configuration
REQ-022 SHALL support macro ARB2_MERGE_STATS_EN: when defined, add outputs grant_cnt0/grant_cnt1 (16 bits each) counting output-register loads per input, saturating at 16'hFFFF, cleared by reset.
REQ-023 SHALL, when ARB2_MERGE_STATS_EN is undefined, omit the counters and ports entirely with no other behavioural change.

Structure
REQ-024 SHALL place flit width constant (FLIT_W=9), address field bounds ([8:5]) and flit typedef in shared package noc_pkg.
REQ-025 SHALL implement the per-input buffer as one sub-module noc_fifo (parameters W, DEPTH), instantiated twice.

Verification
REQ-026 Reset release, in0 sends 9'h0A5, out_ready=1 -> out_data=9'h0A5, out_src=0 one cycle after acceptance.
REQ-027 Both inputs valid every cycle (in0=9'h100.., in1=9'h0E0..), out_ready=1 -> out_src alternates 0,1,0,1 starting with 0; one flit/cycle.
REQ-028 out_ready=0 for 10 cycles while in1 streams -> in1_ready drops to 0 after DEPTH+1 accepted flits; out_data unchanged; on release, all flits emerge in order.
REQ-029 Only in1 valid for 4 flits -> all granted to in1 back-to-back, no idle cycles for in0.
REQ-030 Assert _RESET for 1 cycle with both FIFOs full -> out_valid=0 immediately; no pre-reset flit appears afterward.
REQ-031 With ARB2_MERGE_STATS_EN, 3 flits in0 and 5 flits in1 drained -> grant_cnt0=3, grant_cnt1=5.
